// File: rtl/mfp_srec_ahb_write_buffer.sv
// Coalesces parser bytes into word entries, queues them, and drains each as one AHB-Lite word or per-byte writes.
// A pushed entry drives NONSEQ two edges after the push; the parser is never stalled, so a push into a full FIFO drops the byte and sets overflow.

module mfp_srec_ahb_write_buffer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage is not reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
endmodule

module mfp_srec_ahb_write_buffer #(
  parameter int         FIFO_DEPTH = 8,
  parameter int         IDLE_FLUSH = 64,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        big_endian,
  input  logic [31:0] write_address,
  input  logic [7:0]  write_byte,
  input  logic        write_enable,
  input  logic        flush,
  input  logic        HREADY,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  output logic        busy,
  output logic        overflow
);
  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  mask;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  function automatic logic [1:0] first_lane(input logic [3:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    if (m[2]) return 2'd2;
    return 2'd3;
  endfunction

  entry_t      acc, acc_nxt, acc_b, byte_ent, merged, push_ent, pop_ent;
  logic        flush_pend, flush_pend_nxt, flush_req, timeout;
  logic        byte_push, flush_push, push, pop, drop;
  logic        fifo_full, fifo_empty;
  logic [1:0]  lane;
  logic [31:0] idle_cnt;

  state_t      state;
  logic [29:0] w_wa;
  logic [31:0] w_data;
  logic [3:0]  w_rem;
  logic [1:0]  w_lane;
  logic        w_full, w_be;
  logic [1:0]  pop_lane, rem_lane, pos;
  logic        pop_full;
  logic [7:0]  lane_byte;
  logic [31:0] wdata;

  assign lane          = write_address[1:0];
  assign byte_ent.wa   = write_address[31:2];
  assign byte_ent.data = 32'(write_byte) << {lane, 3'b000};
  assign byte_ent.mask = 4'b0001 << lane;
  assign merged.wa     = acc.wa;
  assign merged.data   = acc.data | byte_ent.data;
  assign merged.mask   = acc.mask | byte_ent.mask;

  assign timeout   = (IDLE_FLUSH != 0) && !write_enable && (idle_cnt >= 32'(IDLE_FLUSH - 1));
  assign flush_req = flush || flush_pend || timeout;

  // The incoming byte is resolved first; a flush only gets the push slot if the byte left it free.
  always_comb begin
    acc_b      = acc;
    byte_push  = 1'b0;
    flush_push = 1'b0;
    push_ent   = acc;
    if (write_enable) begin
      if (acc.mask == 4'h0) begin
        acc_b = byte_ent;
      end else if (acc.wa == byte_ent.wa && !acc.mask[lane]) begin
        if (merged.mask == 4'hF) begin
          byte_push = 1'b1;
          push_ent  = merged;
          acc_b     = '0;
        end else begin
          acc_b = merged;
        end
      end else begin
        byte_push = 1'b1;
        push_ent  = acc;
        acc_b     = byte_ent;
      end
    end
    if (!byte_push && flush_req && acc_b.mask != 4'h0) begin
      flush_push = 1'b1;
      push_ent   = acc_b;
    end
  end

  always_comb begin
    push = (byte_push || flush_push) && (!fifo_full || pop);
    drop = byte_push && fifo_full && !pop;
    if (drop)                acc_nxt = acc;
    else if (flush_push && push) acc_nxt = '0;
    else                     acc_nxt = acc_b;
    flush_pend_nxt = (flush || flush_pend) && (acc_nxt.mask != 4'h0);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      acc        <= '0;
      flush_pend <= 1'b0;
      idle_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      acc        <= acc_nxt;
      flush_pend <= flush_pend_nxt;
      if (write_enable)                      idle_cnt <= '0;
      else if (idle_cnt < 32'(IDLE_FLUSH))   idle_cnt <= idle_cnt + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  mfp_srec_ahb_write_buffer_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (HCLK),
    .rst      (HRESET),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .pop_dat  (pop_ent),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign pop      = (state == IDLE) && !fifo_empty;
  assign pop_full = (pop_ent.mask == 4'hF);
  assign pop_lane = first_lane(pop_ent.mask);
  assign rem_lane = first_lane(w_rem);

  always_comb begin
    lane_byte = 8'(w_data >> {w_lane, 3'b000});
    pos       = w_be ? ~w_lane : w_lane;
    if (w_full) wdata = w_be ? {w_data[7:0], w_data[15:8], w_data[23:16], w_data[31:24]} : w_data;
    else        wdata = 32'(lane_byte) << {pos, 3'b000};
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= IDLE;
      HADDR  <= '0;
      HSIZE  <= '0;
      HTRANS <= 2'b00;
      HWRITE <= 1'b0;
      HWDATA <= '0;
      w_wa   <= '0;
      w_data <= '0;
      w_rem  <= '0;
      w_lane <= '0;
      w_full <= 1'b0;
      w_be   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!fifo_empty) begin
          w_wa   <= pop_ent.wa;
          w_data <= pop_ent.data;
          w_be   <= big_endian;
          w_full <= pop_full;
          w_lane <= pop_lane;
          w_rem  <= pop_full ? 4'h0 : (pop_ent.mask & ~(4'b0001 << pop_lane));
          HADDR  <= {pop_ent.wa, pop_full ? 2'b00 : pop_lane};
          HSIZE  <= pop_full ? 3'b010 : 3'b000;
          HTRANS <= 2'b10;
          HWRITE <= 1'b1;
          state  <= ADDR;
        end
        ADDR: if (HREADY) begin
          HTRANS <= 2'b00;
          HWRITE <= 1'b0;
          HWDATA <= wdata;
          state  <= DATA;
        end
        DATA: if (HREADY) begin
          if (w_rem != 4'h0) begin
            w_lane <= rem_lane;
            w_rem  <= w_rem & ~(4'b0001 << rem_lane);
            HADDR  <= {w_wa, rem_lane};
            HSIZE  <= 3'b000;
            HTRANS <= 2'b10;
            HWRITE <= 1'b1;
            state  <= ADDR;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (acc.mask != 4'h0) || !fifo_empty || (state != IDLE);
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VAL;
endmodule

// File: tb/tb_mfp_srec_ahb_write_buffer.sv
// Scoreboard bench: expected AHB transfers are queued with the stimulus and checked by a bus monitor.
module tb_mfp_srec_ahb_write_buffer;
  localparam int DEPTH = 2;
  localparam int IDLE  = 20;

  logic        clk = 1'b0;
  logic        hreset, big_endian, write_enable, flush, hready;
  logic [31:0] write_address;
  logic [7:0]  write_byte;
  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HBURST, HSIZE;
  logic        HMASTLOCK, HWRITE, busy, overflow;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } xfer_t;

  xfer_t sb[$];
  xfer_t cur;
  bit    dph;
  int    checks, errors;

  always #5 clk = ~clk;

  mfp_srec_ahb_write_buffer #(.FIFO_DEPTH(DEPTH), .IDLE_FLUSH(IDLE), .HPROT_VAL(4'b0011)) dut (
    .HCLK(clk), .HRESET(hreset), .big_endian(big_endian), .write_address(write_address),
    .write_byte(write_byte), .write_enable(write_enable), .flush(flush), .HREADY(hready),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .busy(busy), .overflow(overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_xfer(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    xfer_t x;
    x.addr = a; x.size = s; x.data = d;
    sb.push_back(x);
  endtask

  task automatic wr_byte(input logic [31:0] a, input logic [7:0] d);
    write_address = a; write_byte = d; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    for (int j = 0; j < 4; j++) wr_byte(a + 32'(j), d[8*j +: 8]);
  endtask

  // Samples at the falling edge what the DUT will see at the next rising edge.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (hreset) begin
        dph = 1'b0;
      end else begin
        if (dph && hready) begin
          checks++;
          if (HWDATA !== cur.data) begin errors++; $display("FAIL hwdata @%h: got %h expected %h", cur.addr, HWDATA, cur.data); end
          dph = 1'b0;
        end
        if (HTRANS === 2'b10 && hready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++; $display("FAIL unexpected transfer: HADDR=%h HSIZE=%0d", HADDR, HSIZE);
          end else begin
            cur = sb.pop_front();
            if (HADDR !== cur.addr || HSIZE !== cur.size) begin
              errors++; $display("FAIL addr_phase: got %h/%0d expected %h/%0d", HADDR, HSIZE, cur.addr, cur.size);
            end
            dph = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((busy || sb.size() != 0 || dph) && n < 400) begin tick(); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL %s drain timeout: busy=%0b pending=%0d", name, busy, sb.size()); end
  endtask

  task automatic wait_nonseq(input string name, output int n);
    n = 0;
    while (HTRANS !== 2'b10 && n < 100) begin tick(); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL %s nonseq timeout: HTRANS=%0d expected 2", name, HTRANS); end
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    repeat (3) tick();
    checks++; if (HADDR !== 32'h0)  begin errors++; $display("FAIL reset_haddr: got %h expected 0", HADDR); end
    checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL reset_hwdata: got %h expected 0", HWDATA); end
    checks++; if (HSIZE !== 3'd0)   begin errors++; $display("FAIL reset_hsize: got %0d expected 0", HSIZE); end
    checks++; if (HTRANS !== 2'd0)  begin errors++; $display("FAIL reset_htrans: got %0d expected 0", HTRANS); end
    checks++; if (HWRITE !== 1'b0)  begin errors++; $display("FAIL reset_hwrite: got %0b expected 0", HWRITE); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    checks++; if (HBURST !== 3'd0 || HMASTLOCK !== 1'b0 || HPROT !== 4'b0011) begin
      errors++; $display("FAIL reset_constants: got %0d/%0b/%h expected 0/0/3", HBURST, HMASTLOCK, HPROT);
    end
    hreset = 1'b0;
    tick();
  endtask

  task automatic test_full_word(input logic be, input logic [31:0] exp_data);
    hready = 1'b1; big_endian = be;
    expect_xfer(32'h100, 3'd2, exp_data);
    wr_byte(32'h100, 8'h11); wr_byte(32'h101, 8'h22); wr_byte(32'h102, 8'h33); wr_byte(32'h103, 8'h44);
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL word_latency_early: HTRANS=%0d expected 0", HTRANS); end
    tick();
    checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL word_latency: HTRANS=%0d expected 2", HTRANS); end
    checks++; if (HWRITE !== 1'b1) begin errors++; $display("FAIL word_hwrite: got %0b expected 1", HWRITE); end
    wait_drain("full_word");
    big_endian = 1'b0;
  endtask

  task automatic test_partial_flush();
    int n;
    hready = 1'b0;
    expect_xfer(32'h201, 3'd0, 32'h0000AA00);
    expect_xfer(32'h203, 3'd0, 32'hBB000000);
    wr_byte(32'h201, 8'hAA); wr_byte(32'h203, 8'hBB);
    tick();
    checks++; if (HTRANS !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL partial_hold: HTRANS=%0d busy=%0b expected 0/1", HTRANS, busy); end
    flush = 1'b1; tick(); flush = 1'b0;
    wait_nonseq("partial", n);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (HTRANS !== 2'b10 || HADDR !== 32'h201 || HSIZE !== 3'd0) begin
        errors++; $display("FAIL partial_stall: HTRANS=%0d HADDR=%h HSIZE=%0d expected 2/201/0", HTRANS, HADDR, HSIZE);
      end
    end
    hready = 1'b1;
    wait_drain("partial_flush");
  endtask

  task automatic test_back_to_back();
    hready = 1'b1;
    expect_xfer(32'h600, 3'd0, 32'h000000CC);
    expect_xfer(32'h605, 3'd0, 32'h0000DD00);
    expect_xfer(32'h800, 3'd0, 32'h00000011);
    expect_xfer(32'h800, 3'd0, 32'h00000022);
    wr_byte(32'h600, 8'hCC);
    flush = 1'b1; wr_byte(32'h605, 8'hDD); flush = 1'b0;
    wr_byte(32'h800, 8'h11); wr_byte(32'h800, 8'h22);
    flush = 1'b1; tick(); flush = 1'b0;
    wait_drain("back_to_back");
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %0b expected 0", overflow); end
  endtask

  task automatic test_stall_words();
    int n;
    logic [31:0] wd [8];
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) wd[i][8*j +: 8] = 8'hA0 + 8'(4*i + j);
      expect_xfer(32'h500 + 32'(4*i), 3'd2, wd[i]);
    end
    hready = 1'b0;
    wr_word(32'h500, wd[0]);
    wait_nonseq("stall", n);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (HTRANS !== 2'b10 || HADDR !== 32'h500 || HSIZE !== 3'd2) begin
        errors++; $display("FAIL stall_stable: HTRANS=%0d HADDR=%h HSIZE=%0d expected 2/500/2", HTRANS, HADDR, HSIZE);
      end
    end
    hready = 1'b1;
    for (int i = 1; i < 8; i++) wr_word(32'h500 + 32'(4*i), wd[i]);
    wait_drain("stall_words");
  endtask

  task automatic test_idle_flush();
    int n;
    hready = 1'b1;
    expect_xfer(32'h300, 3'd0, 32'h00000099);
    wr_byte(32'h300, 8'h99);
    repeat (IDLE - 2) tick();
    checks++; if (HTRANS !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL idle_early: HTRANS=%0d busy=%0b expected 0/1", HTRANS, busy); end
    wait_nonseq("idle_flush", n);
    checks++; if (IDLE - 2 + n !== IDLE + 1) begin errors++; $display("FAIL idle_latency: nonseq after %0d cycles expected %0d", IDLE - 2 + n, IDLE + 1); end
    wait_drain("idle_flush");
  endtask

  task automatic test_overflow();
    hready = 1'b0;
    expect_xfer(32'h400, 3'd2, 32'h53525150);
    expect_xfer(32'h404, 3'd2, 32'h57565554);
    expect_xfer(32'h408, 3'd2, 32'h5B5A5958);
    expect_xfer(32'h40C, 3'd0, 32'h0000005C);
    expect_xfer(32'h40D, 3'd0, 32'h00005D00);
    expect_xfer(32'h40E, 3'd0, 32'h005E0000);
    for (int i = 0; i < 15; i++) wr_byte(32'h400 + 32'(i), 8'h50 + 8'(i));
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_early: got %0b expected 0", overflow); end
    wr_byte(32'h40F, 8'h5F);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %0b expected 1", overflow); end
    repeat (3) tick();
    hready = 1'b1;
    wait_drain("overflow");
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %0b expected 1", overflow); end
  endtask

  task automatic test_reset_mid_data();
    int n;
    hready = 1'b1;
    expect_xfer(32'h900, 3'd2, 32'h04030201);
    wr_word(32'h900, 32'h04030201);
    wait_nonseq("reset_mid", n);
    tick();
    hready = 1'b0;
    checks++; if (HTRANS !== 2'b00 || HWRITE !== 1'b0) begin errors++; $display("FAIL mid_data_phase: HTRANS=%0d HWRITE=%0b expected 0/0", HTRANS, HWRITE); end
    wr_byte(32'hA00, 8'h77);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0b expected 1", busy); end
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    checks++; if (busy !== 1'b0 || HTRANS !== 2'b00) begin errors++; $display("FAIL reset_abort: busy=%0b HTRANS=%0d expected 0/0", busy, HTRANS); end
    checks++; if (HWDATA !== 32'h0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_abort_regs: HWDATA=%h overflow=%0b expected 0/0", HWDATA, overflow); end
    hready = 1'b1;
    repeat (IDLE + 5) tick();
    checks++; if (busy !== 1'b0 || HTRANS !== 2'b00) begin errors++; $display("FAIL reset_cleared_acc: busy=%0b HTRANS=%0d expected 0/0", busy, HTRANS); end
  endtask

  initial begin
    hreset = 1'b1; big_endian = 1'b0; write_enable = 1'b0; flush = 1'b0; hready = 1'b1;
    write_address = '0; write_byte = '0;
    checks = 0; errors = 0; dph = 1'b0;
    fork monitor(); join_none
    test_reset();
    test_full_word(1'b0, 32'h44332211);
    test_full_word(1'b1, 32'h11223344);
    test_partial_flush();
    test_back_to_back();
    test_stall_words();
    test_idle_flush();
    test_overflow();
    test_reset_mid_data();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL leftover_expected: %0d transfers never seen, expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
